// File: rtl/song_pkg.sv
// Shared types and helpers for the song sequencer: FSM state encoding,
// default rest/end marker words, note-field positions and the saturating
// octave transposition function.
package song_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CHECK = 3'd2,
        ST_PLAY  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [8:0] REST_CODE_DEF = 9'h111;
    localparam logic [8:0] END_CODE_DEF  = 9'h000;

    // Note word layout: pitch code above, octave in the low nibble.
    localparam int OCT_LSB   = 0;
    localparam int OCT_MSB   = 3;
    localparam int PITCH_LSB = 4;

    // Adds a signed -4..+3 offset to a 0..15 octave, clamping at both ends.
    function automatic logic [3:0] oct_shift(input logic [3:0] oct,
                                             input logic [2:0] shift);
        logic signed [5:0] sum;
        sum = $signed({2'b00, oct}) + $signed({{3{shift[2]}}, shift});
        if (sum < 6'sd0) begin
            oct_shift = 4'd0;
        end else if (sum > 6'sd15) begin
            oct_shift = 4'd15;
        end else begin
            oct_shift = sum[3:0];
        end
    endfunction

endpackage

// File: rtl/song_rom.sv
// Note memory for the song sequencer: synchronous-read ROM whose contents
// are provided by the surrounding environment.
module song_rom #(
    parameter int    NOTE_W    = 9,
    parameter int    SONG_LEN  = 128,
    parameter int    ADDR_W    = $clog2(SONG_LEN),
    parameter string SONG_FILE = "song.hex"
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NOTE_W-1:0] o_data
);

    logic [NOTE_W-1:0] mem [SONG_LEN];
    logic [NOTE_W-1:0] data_q;

    // Registered read: address presented this cycle, word available next.
    always_ff @(posedge i_clk) begin
        data_q <= mem[i_addr];
    end

    assign o_data = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: steps through the note ROM at a programmable tempo,
// transposes each note by a signed octave offset and strobes it out to the
// tone generator. Supports play/pause/stop, end marker, loop/one-shot.
// Optional macro SONG_SEQUENCER_GAP_EN: drop o_Gate for the last
// GAP_CYCLES of every step so repeated notes are separated.
module song_sequencer
    import song_pkg::*;
#(
    parameter int              NOTE_W      = 9,
    parameter int              SONG_LEN    = 128,
    parameter int              ADDR_W      = $clog2(SONG_LEN),
    parameter int              TICK_CYCLES = 6250000,
    parameter logic [NOTE_W-1:0] REST_CODE = REST_CODE_DEF,
    parameter logic [NOTE_W-1:0] END_CODE  = END_CODE_DEF,
    parameter string           SONG_FILE   = "song.hex",
    parameter int              GAP_CYCLES  = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_Play,
    input  logic              i_Pause,
    input  logic              i_Stop,
    input  logic              i_Loop,
    input  logic [1:0]        i_TempoDiv,
    input  logic [2:0]        i_OctShift,
    output logic [NOTE_W-1:0] o_Note,
    output logic              o_NextNote,
    output logic              o_Gate,
    output logic [ADDR_W-1:0] o_Index,
    output logic              o_Playing,
    output logic              o_Done
);

    // Counter wide enough for TICK_CYCLES << 3.
    localparam int                CNT_W   = $clog2(TICK_CYCLES) + 4;
    localparam logic [CNT_W-1:0]  TICK_L  = CNT_W'(TICK_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(SONG_LEN - 1);

    if (SONG_LEN < 2 || TICK_CYCLES < 1 || GAP_CYCLES < 0) begin : g_param_check
        $error("song_sequencer: unsupported parameter values");
    end

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [CNT_W-1:0]  tick_q,    tick_d;
    logic [CNT_W-1:0]  len_q,     len_d;
    logic [NOTE_W-1:0] note_q,    note_d;
    logic [ADDR_W-1:0] index_q,   index_d;
    logic              strobe_q,  strobe_d;
    logic              gate_q,    gate_d;
    logic              playing_q, playing_d;
    logic              done_q,    done_d;

    logic [NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0] xpose_note;

    song_rom #(
        .NOTE_W    (NOTE_W),
        .SONG_LEN  (SONG_LEN),
        .ADDR_W    (ADDR_W),
        .SONG_FILE (SONG_FILE)
    ) u_rom (
        .i_clk  (i_clk),
        .i_addr (addr_q),
        .o_data (rom_data)
    );

    // Rest words pass straight through; everything else gets its octave shifted.
    assign xpose_note = (rom_data == REST_CODE) ? rom_data :
                        {rom_data[NOTE_W-1:PITCH_LSB],
                         oct_shift(rom_data[OCT_MSB:OCT_LSB], i_OctShift)};

    // Next-state and datapath decisions; Stop overrides everything.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tick_d   = tick_q;
        len_d    = len_q;
        note_d   = note_q;
        index_d  = index_q;
        strobe_d = 1'b0;
        if (i_Stop) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            tick_d  = '0;
            note_d  = REST_CODE;
            index_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_Play && !i_Pause) begin
                        state_d = ST_FETCH;
                        addr_d  = '0;
                        tick_d  = '0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (rom_data == END_CODE) begin
                        // A song that starts with the marker would spin forever in loop mode.
                        if (i_Loop && addr_q != '0) begin
                            state_d = ST_FETCH;
                            addr_d  = '0;
                        end else begin
                            state_d = ST_DONE;
                            note_d  = REST_CODE;
                        end
                    end else begin
                        state_d  = ST_PLAY;
                        note_d   = xpose_note;
                        index_d  = addr_q;
                        strobe_d = 1'b1;
                        tick_d   = '0;
                        len_d    = TICK_L << i_TempoDiv;
                    end
                end
                ST_PLAY: begin
                    // The final tick always completes the step; a pause then lands in the next one.
                    if (tick_q == len_q - CNT_W'(1)) begin
                        tick_d = '0;
                        if (addr_q == LAST_A) begin
                            if (i_Loop) begin
                                state_d = ST_FETCH;
                                addr_d  = '0;
                            end else begin
                                state_d = ST_DONE;
                                note_d  = REST_CODE;
                            end
                        end else begin
                            state_d = ST_FETCH;
                            addr_d  = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        // This cycle counts even if it is the one that enters PAUSE.
                        tick_d = tick_q + CNT_W'(1);
                        if (i_Pause) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_Pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    tick_d  = '0;
                    note_d  = REST_CODE;
                    index_d = '0;
                end
            endcase
        end
    end

    // Gate is computed from the next state so it aligns with the registered note.
    always_comb begin
        gate_d = 1'b0;
        if (state_d == ST_PLAY && note_d != REST_CODE) begin
`ifdef SONG_SEQUENCER_GAP_EN
            gate_d = ((32'(tick_d) + 32'(GAP_CYCLES)) < 32'(len_d));
`else
            gate_d = 1'b1;
`endif
        end else begin
            gate_d = 1'b0;
        end
    end

    // Status flags decoded from the next state so outputs stay registered.
    always_comb begin
        playing_d = (state_d == ST_FETCH) || (state_d == ST_PLAY);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tick_q    <= '0;
            len_q     <= '0;
            note_q    <= REST_CODE;
            index_q   <= '0;
            strobe_q  <= 1'b0;
            gate_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tick_q    <= tick_d;
            len_q     <= len_d;
            note_q    <= note_d;
            index_q   <= index_d;
            strobe_q  <= strobe_d;
            gate_q    <= gate_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign o_Note     = note_q;
    assign o_NextNote = strobe_q;
    assign o_Gate     = gate_q;
    assign o_Index    = index_q;
    assign o_Playing  = playing_q;
    assign o_Done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_CYCLES=4, SONG_LEN=8.
// Note memory contents are written directly into the ROM instance.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, play, pause, stop, loop;
    logic [1:0] tempo;
    logic [2:0] oct;
    logic [8:0] o_note;
    logic       o_next, o_gate, o_playing, o_done;
    logic [2:0] o_index;

    int total = 0;
    int bad   = 0;

    song_sequencer #(
        .NOTE_W(9), .SONG_LEN(8), .ADDR_W(3), .TICK_CYCLES(4),
        .REST_CODE(9'h111), .END_CODE(9'h000), .SONG_FILE(""), .GAP_CYCLES(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_Play(play), .i_Pause(pause),
        .i_Stop(stop), .i_Loop(loop), .i_TempoDiv(tempo), .i_OctShift(oct),
        .o_Note(o_note), .o_NextNote(o_next), .o_Gate(o_gate),
        .o_Index(o_index), .o_Playing(o_playing), .o_Done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] word;
        logic [2:0] shift;
        logic [8:0] exp_note;
        logic       exp_gate;
    } xp_vec_t;

    xp_vec_t vec [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [71:0] words);
        for (int i = 0; i < 8; i++) begin
            dut.u_rom.mem[i] = words[71-9*i -: 9];
        end
    endtask

    task automatic pulse_play();
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    task automatic wait_strobe(input string name, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_next !== 1'b1 && n < max);
        if (o_next !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: no strobe within %0d cycles", name, max);
        end
    endtask

    task automatic wait_done(input string name, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_done !== 1'b1 && n < max);
        if (o_done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: not done within %0d cycles", name, max);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " note"},    32'(o_note),    32'h111);
        check({tag, " index"},   32'(o_index),   32'h0);
        check({tag, " strobe"},  32'(o_next),    32'h0);
        check({tag, " gate"},    32'(o_gate),    32'h0);
        check({tag, " playing"}, 32'(o_playing), 32'h0);
        check({tag, " done"},    32'(o_done),    32'h0);
    endtask

    // File used by timing, loop, pause and reset scenarios.
    localparam logic [71:0] FILE_A = {9'h0E7, 9'h111, 9'h0C7, 9'h006,
                                      9'h000, 9'h000, 9'h000, 9'h000};
    localparam logic [71:0] FILE_F = {9'h0E7, 9'h0C7, 9'h006, 9'h0E7,
                                      9'h0E7, 9'h0C7, 9'h006, 9'h0D5};

    initial begin
        int n, gh, cnt;
        logic [8:0] exp_n [4];
        logic       exp_g [4];
        logic [8:0] full_w;
        logic [3:0] pat, exp_pat;

        vec[0] = '{9'h0E7, 3'd3, 9'h0EA, 1'b1};
        vec[1] = '{9'h0ED, 3'd3, 9'h0EF, 1'b1};  // saturates high
        vec[2] = '{9'h006, 3'd4, 9'h002, 1'b1};  // -4
        vec[3] = '{9'h111, 3'd3, 9'h111, 1'b0};  // rest untouched
        vec[4] = '{9'h0E2, 3'd4, 9'h0E0, 1'b1};  // saturates low
        vec[5] = '{9'h0C5, 3'd0, 9'h0C5, 1'b1};
        vec[6] = '{9'h0A1, 3'd7, 9'h0A0, 1'b1};  // -1
        vec[7] = '{9'h0B9, 3'd4, 9'h0B5, 1'b1};

        exp_n[0] = 9'h0E7; exp_n[1] = 9'h111; exp_n[2] = 9'h0C7; exp_n[3] = 9'h006;
        exp_g[0] = 1'b1;   exp_g[1] = 1'b0;   exp_g[2] = 1'b1;   exp_g[3] = 1'b1;

        rst_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0;
        tempo = 2'd0; oct = 3'd0;
        load(FILE_A);
        tick(); tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Step timing, one-shot, tempo 0.
        pulse_play();
        wait_strobe("t1 first", 20, n);
        check("t1 first latency", 32'(n), 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_strobe("t1 step", 20, n);
                check("t1 interval", 32'(n), 32'd6);
            end
            check("t1 note",  32'(o_note),  32'(exp_n[i]));
            check("t1 index", 32'(o_index), 32'(i));
            check("t1 gate",  32'(o_gate),  32'(exp_g[i]));
        end
        wait_done("t1 done", 20, n);
        check("t1 done latency", 32'(n), 32'd6);
        check("t1 done note", 32'(o_note), 32'h111);
        check("t1 done gate", 32'(o_gate), 32'h0);
        check("t1 done playing", 32'(o_playing), 32'h0);

        // Transposition table: single-note songs, one-shot.
        for (int v = 0; v < 8; v++) begin
            load({vec[v].word, 9'h000, 54'd0});
            oct = vec[v].shift;
            pulse_play();
            wait_strobe("xp strobe", 20, n);
            check("xp note",  32'(o_note),  32'(vec[v].exp_note));
            check("xp gate",  32'(o_gate),  32'(vec[v].exp_gate));
            check("xp index", 32'(o_index), 32'h0);
            wait_done("xp done", 20, n);
        end
        oct = 3'd0;

        // Loop mode with tempo 2 (16-cycle steps).
        load(FILE_A);
        loop = 1'b1;
        tempo = 2'd2;
        pulse_play();
        wait_strobe("loop first", 30, n);
        for (int i = 1; i < 4; i++) begin
            wait_strobe("loop step", 40, n);
            check("loop interval", 32'(n), 32'd18);
            check("loop note", 32'(o_note), 32'(exp_n[i]));
        end
        wait_strobe("loop wrap", 40, n);
        check("loop wrap interval", 32'(n), 32'd20);
        check("loop wrap note",  32'(o_note),  32'h0E7);
        check("loop wrap index", 32'(o_index), 32'h0);
        wait_strobe("loop after wrap", 40, n);
        check("loop after wrap interval", 32'(n), 32'd18);
        check("loop after wrap note", 32'(o_note), 32'h111);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop stop note",    32'(o_note),    32'h111);
        check("loop stop playing", 32'(o_playing), 32'h0);
        loop = 1'b0;
        tempo = 2'd0;
        tick();

        // Pause for 10 cycles right after a strobe.
        pulse_play();
        wait_strobe("pause first", 20, n);
        pause = 1'b1;
        gh = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_gate === 1'b1) gh++;
        end
        check("pause gate", 32'(gh), 32'd0);
        check("pause held note", 32'(o_note), 32'h0E7);
        pause = 1'b0;
        wait_strobe("pause resume", 30, n);
        check("pause delay", 32'(10 + n), 32'd16);
        check("pause next note", 32'(o_note), 32'h111);
        stop = 1'b1;
        play = 1'b1;
        tick();
        stop = 1'b0;
        play = 1'b0;
        check("stop index",   32'(o_index),   32'h0);
        check("stop strobe",  32'(o_next),    32'h0);
        check("stop note",    32'(o_note),    32'h111);
        check("stop playing", 32'(o_playing), 32'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_next === 1'b1) cnt++;
        end
        check("stop no strobe", 32'(cnt), 32'd0);

        // Reset in the middle of the note at index 3.
        pulse_play();
        for (int i = 0; i < 4; i++) begin
            wait_strobe("rst walk", 20, n);
        end
        check("rst pre index", 32'(o_index), 32'h3);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        tick();
        pulse_play();
        wait_strobe("rst restart", 20, n);
        check("rst restart index", 32'(o_index), 32'h0);
        check("rst restart note",  32'(o_note),  32'h0E7);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Full memory without end marker, one-shot; gate pattern per step.
`ifdef SONG_SEQUENCER_GAP_EN
        exp_pat = 4'b1110;
`else
        exp_pat = 4'b1111;
`endif
        load(FILE_F);
        pulse_play();
        for (int i = 0; i < 8; i++) begin
            wait_strobe("full strobe", 20, n);
            full_w = FILE_F[71-9*i -: 9];
            check("full index", 32'(o_index), 32'(i));
            check("full note",  32'(o_note),  32'(full_w));
            pat[3] = o_gate;
            tick(); pat[2] = o_gate;
            tick(); pat[1] = o_gate;
            tick(); pat[0] = o_gate;
            check("full gate pattern", 32'(pat), 32'(exp_pat));
        end
        tick();
        check("full done", 32'(o_done), 32'h1);
        check("full done note", 32'(o_note), 32'h111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
